// File: rtl/scratchpad_wordport.sv
// scratchpad_wordport: word-wide request/response front end for one byteram
// bank. Each request is split into one byte access per cycle on the
// single-port byteram. For reads, the returned bytes are assembled into a word.
// Exactly one response is returned for each accepted request.
//
// Handshake semantics (both channels): a transfer happens on the rising clk
// edge where valid && ready are both high. Once resp_valid rises, it stays
// high with resp_write and resp_rdata unchanged until that transfer happens.
// req_ready depends only on state and rst; it never depends on req_valid.
module scratchpad_wordport #(
    parameter int AddrW     = 10,
    parameter int WordBytes = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [AddrW-1:0]       req_addr,
    input  logic [8*WordBytes-1:0] req_wdata,
    input  logic [WordBytes-1:0]   req_bmask,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_write,
    output logic [8*WordBytes-1:0] resp_rdata,
    output logic [AddrW-1:0]       ram_addr,
    output logic                   ram_web,
    output logic [7:0]             ram_ibyte,
    input  logic [7:0]             ram_obyte,
    output logic [1:0]             state_dbg
);

    localparam int W  = 8 * WordBytes;
    localparam int CW = $clog2(WordBytes + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;      // WR: byte on the bus; RD: cycles since the first address
    logic [W-1:0]           wdata_q;  // remaining write bytes, next one in [7:0]
    logic [WordBytes-1:0]   mask_q;   // remaining byte enables, next one in [0]
    logic                   web_q;

    // Accept only in IDLE, and never while reset is held.
    assign req_ready = (state == IDLE) && !rst;

    // Reset forces web high in the same cycle, so an abandoned write
    // cannot commit the byte that is on the bus at that moment.
    assign ram_web   = web_q | rst;

    assign state_dbg = state;

    // Request FSM: latch the request, step one byte per cycle, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            web_q      <= 1'b1;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
            ram_addr   <= '0;
            ram_ibyte  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        resp_write <= req_write;
                        resp_rdata <= '0;
                        ram_addr   <= req_addr;
                        cnt        <= '0;
                        if (req_write) begin
                            ram_ibyte <= req_wdata[7:0];
                            web_q     <= !req_bmask[0];
                            wdata_q   <= req_wdata >> 8;
                            mask_q    <= req_bmask >> 1;
                            state     <= WR;
                        end else begin
                            web_q <= 1'b1;
                            state <= RD;
                        end
                    end
                end
                WR: begin
                    if (cnt == CW'(WordBytes - 1)) begin
                        web_q      <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        ram_addr  <= ram_addr + 1'b1;
                        ram_ibyte <= wdata_q[7:0];
                        web_q     <= !mask_q[0];
                        wdata_q   <= wdata_q >> 8;
                        mask_q    <= mask_q >> 1;
                    end
                end
                RD: begin
                    // The byte for address k appears on obyte while cnt == k+1.
                    for (int k = 0; k < WordBytes; k++) begin
                        if (cnt == CW'(k + 1)) begin
                            resp_rdata[8*k +: 8] <= ram_obyte;
                        end
                    end
                    if (cnt == CW'(WordBytes)) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt < CW'(WordBytes - 1)) begin
                            ram_addr <= ram_addr + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
